// File: rtl/e203_exu_pkg.sv
// Shared execution-unit definitions: OITF entry layout and default long-pipe sizing.
package e203_exu_pkg;

  localparam int OITF_DEPTH_DEF = 4;
  localparam int ITAG_W_DEF     = 2;

  typedef struct packed {
    logic        rdwen;
    logic [4:0]  rdidx;
    logic [31:0] pc;
  } oitf_entry_t;

endpackage

// File: rtl/e203_exu_oitf_ptr.sv
// OITF read/write pointers with wrap bit; derives full/empty and exposes the low index bits as tags.
module e203_exu_oitf_ptr
  import e203_exu_pkg::*;
#(
  parameter int ITAG_W = ITAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_fire,
  input  logic              retire_fire,
  output logic [ITAG_W-1:0] wr_idx,
  output logic [ITAG_W-1:0] rd_idx,
  output logic              full,
  output logic              empty
);

  logic [ITAG_W:0] wr_ptr;
  logic [ITAG_W:0] rd_ptr;

  // Natural (ITAG_W+1)-bit overflow gives the modulo 2*depth wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (alloc_fire)  wr_ptr <= wr_ptr + 1'b1;
      if (retire_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign wr_idx = wr_ptr[ITAG_W-1:0];
  assign rd_idx = rd_ptr[ITAG_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ITAG_W-1:0] == rd_ptr[ITAG_W-1:0]) &&
                  (wr_ptr[ITAG_W] != rd_ptr[ITAG_W]);

endmodule

// File: rtl/e203_exu_longp_wbck.sv
// Long-pipe writeback: OITF tracking of outstanding LSU ops, in-order retire, RF write arbitration.
// Optional feature macro: E203_LONGP_EXCP_EN (LSU bus-error exceptions to commit).
module e203_exu_longp_wbck
  import e203_exu_pkg::*;
#(
  parameter int OITF_DEPTH = OITF_DEPTH_DEF,
  parameter int ITAG_W     = ITAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              disp_alloc_valid,
  output logic              disp_alloc_ready,
  input  logic              disp_alloc_rdwen,
  input  logic [4:0]        disp_alloc_rdidx,
  input  logic [31:0]       disp_alloc_pc,
  output logic [ITAG_W-1:0] disp_alloc_itag,
  output logic              oitf_empty,

  input  logic              lsu_i_valid,
  output logic              lsu_i_ready,
  input  logic [31:0]       lsu_i_wdat,
  input  logic [ITAG_W-1:0] lsu_i_itag,
  input  logic              lsu_i_err,
  input  logic              lsu_i_ld,
  input  logic              lsu_i_st,
  input  logic [31:0]       lsu_i_badaddr,

  input  logic              alu_wbck_i_valid,
  output logic              alu_wbck_i_ready,
  input  logic [31:0]       alu_wbck_i_wdat,
  input  logic [4:0]        alu_wbck_i_rdidx,

  output logic              rf_wbck_ena,
  output logic [31:0]       rf_wbck_wdat,
  output logic [4:0]        rf_wbck_rdidx,

  output logic              longp_excp_o_valid,
  input  logic              longp_excp_o_ready,
  output logic              longp_excp_o_ld,
  output logic              longp_excp_o_st,
  output logic              longp_excp_o_buserr,
  output logic [31:0]       longp_excp_o_badaddr,
  output logic [31:0]       longp_excp_o_pc
);

  if (((1 << ITAG_W) != OITF_DEPTH) || (OITF_DEPTH < 2)) begin : g_param_chk
    $error("OITF_DEPTH must be a power of two >= 2 and equal 2**ITAG_W");
  end

  logic              alloc_fire;
  logic              retire_fire;
  logic              oitf_full;
  logic [ITAG_W-1:0] wr_idx;
  logic [ITAG_W-1:0] rd_idx;
  logic              head_match;
  logic              lsu_err_eff;
  logic              alu_fire;
  oitf_entry_t       oitf_mem [OITF_DEPTH];
  oitf_entry_t       head;

  e203_exu_oitf_ptr #(.ITAG_W(ITAG_W)) u_oitf_ptr (
    .clk         (clk),
    .rst         (rst),
    .alloc_fire  (alloc_fire),
    .retire_fire (retire_fire),
    .wr_idx      (wr_idx),
    .rd_idx      (rd_idx),
    .full        (oitf_full),
    .empty       (oitf_empty)
  );

  assign disp_alloc_ready = !oitf_full;
  assign disp_alloc_itag  = wr_idx;
  assign alloc_fire       = disp_alloc_valid && !oitf_full;

  // Payload storage is deliberately unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      oitf_mem[wr_idx] <= '{rdwen: disp_alloc_rdwen, rdidx: disp_alloc_rdidx, pc: disp_alloc_pc};
    end
  end

  assign head       = oitf_mem[rd_idx];
  assign head_match = !oitf_empty && (lsu_i_itag == rd_idx);

`ifdef E203_LONGP_EXCP_EN
  assign lsu_err_eff          = lsu_i_err;
  assign lsu_i_ready          = head_match && (!lsu_i_err || longp_excp_o_ready);
  assign longp_excp_o_valid   = lsu_i_valid && head_match && lsu_i_err;
  assign longp_excp_o_ld      = lsu_i_ld;
  assign longp_excp_o_st      = lsu_i_st;
  assign longp_excp_o_buserr  = lsu_i_err;
  assign longp_excp_o_badaddr = lsu_i_badaddr;
  assign longp_excp_o_pc      = head.pc;
`else
  logic unused_excp;
  assign unused_excp          = ^{lsu_i_err, lsu_i_ld, lsu_i_st, lsu_i_badaddr,
                                  longp_excp_o_ready, head.pc};
  assign lsu_err_eff          = 1'b0;
  assign lsu_i_ready          = head_match;
  assign longp_excp_o_valid   = 1'b0;
  assign longp_excp_o_ld      = 1'b0;
  assign longp_excp_o_st      = 1'b0;
  assign longp_excp_o_buserr  = 1'b0;
  assign longp_excp_o_badaddr = '0;
  assign longp_excp_o_pc      = '0;
`endif

  assign retire_fire      = lsu_i_valid && lsu_i_ready;
  assign alu_wbck_i_ready = !retire_fire;
  assign alu_fire         = alu_wbck_i_valid && alu_wbck_i_ready;

  // Stage p0: select the writeback source; the long pipe wins over the ALU.
  logic        vld_p0;
  logic [31:0] wdat_p0;
  logic [4:0]  rdidx_p0;

  always_comb begin
    vld_p0   = 1'b0;
    wdat_p0  = alu_wbck_i_wdat;
    rdidx_p0 = alu_wbck_i_rdidx;
    if (retire_fire) begin
      vld_p0   = head.rdwen && !lsu_err_eff;
      wdat_p0  = lsu_i_wdat;
      rdidx_p0 = head.rdidx;
    end else if (alu_fire) begin
      vld_p0   = 1'b1;
    end
  end

  // Stage p1: registered register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wbck_ena   <= 1'b0;
      rf_wbck_wdat  <= '0;
      rf_wbck_rdidx <= '0;
    end else begin
      rf_wbck_ena <= vld_p0;
      if (vld_p0) begin
        rf_wbck_wdat  <= wdat_p0;
        rf_wbck_rdidx <= rdidx_p0;
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_longp_wbck.sv
// Directed self-checking bench for e203_exu_longp_wbck (default 4-entry OITF).
module tb_e203_exu_longp_wbck;

  logic        clk;
  logic        rst;
  logic        disp_alloc_valid;
  logic        disp_alloc_ready;
  logic        disp_alloc_rdwen;
  logic [4:0]  disp_alloc_rdidx;
  logic [31:0] disp_alloc_pc;
  logic [1:0]  disp_alloc_itag;
  logic        oitf_empty;
  logic        lsu_i_valid;
  logic        lsu_i_ready;
  logic [31:0] lsu_i_wdat;
  logic [1:0]  lsu_i_itag;
  logic        lsu_i_err;
  logic        lsu_i_ld;
  logic        lsu_i_st;
  logic [31:0] lsu_i_badaddr;
  logic        alu_wbck_i_valid;
  logic        alu_wbck_i_ready;
  logic [31:0] alu_wbck_i_wdat;
  logic [4:0]  alu_wbck_i_rdidx;
  logic        rf_wbck_ena;
  logic [31:0] rf_wbck_wdat;
  logic [4:0]  rf_wbck_rdidx;
  logic        longp_excp_o_valid;
  logic        longp_excp_o_ready;
  logic        longp_excp_o_ld;
  logic        longp_excp_o_st;
  logic        longp_excp_o_buserr;
  logic [31:0] longp_excp_o_badaddr;
  logic [31:0] longp_excp_o_pc;

  int checks = 0;
  int errors = 0;
  logic [4:0] idx_tab [4] = '{5'd3, 5'd6, 5'd5, 5'd8};

  e203_exu_longp_wbck dut (
    .clk                  (clk),
    .rst                  (rst),
    .disp_alloc_valid     (disp_alloc_valid),
    .disp_alloc_ready     (disp_alloc_ready),
    .disp_alloc_rdwen     (disp_alloc_rdwen),
    .disp_alloc_rdidx     (disp_alloc_rdidx),
    .disp_alloc_pc        (disp_alloc_pc),
    .disp_alloc_itag      (disp_alloc_itag),
    .oitf_empty           (oitf_empty),
    .lsu_i_valid          (lsu_i_valid),
    .lsu_i_ready          (lsu_i_ready),
    .lsu_i_wdat           (lsu_i_wdat),
    .lsu_i_itag           (lsu_i_itag),
    .lsu_i_err            (lsu_i_err),
    .lsu_i_ld             (lsu_i_ld),
    .lsu_i_st             (lsu_i_st),
    .lsu_i_badaddr        (lsu_i_badaddr),
    .alu_wbck_i_valid     (alu_wbck_i_valid),
    .alu_wbck_i_ready     (alu_wbck_i_ready),
    .alu_wbck_i_wdat      (alu_wbck_i_wdat),
    .alu_wbck_i_rdidx     (alu_wbck_i_rdidx),
    .rf_wbck_ena          (rf_wbck_ena),
    .rf_wbck_wdat         (rf_wbck_wdat),
    .rf_wbck_rdidx        (rf_wbck_rdidx),
    .longp_excp_o_valid   (longp_excp_o_valid),
    .longp_excp_o_ready   (longp_excp_o_ready),
    .longp_excp_o_ld      (longp_excp_o_ld),
    .longp_excp_o_st      (longp_excp_o_st),
    .longp_excp_o_buserr  (longp_excp_o_buserr),
    .longp_excp_o_badaddr (longp_excp_o_badaddr),
    .longp_excp_o_pc      (longp_excp_o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", oitf_empty); end
    checks++; if (rf_wbck_ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b want 0", rf_wbck_ena); end
    checks++; if (rf_wbck_wdat !== 32'h0) begin errors++; $display("FAIL reset_wdat: got %h want 0", rf_wbck_wdat); end
    checks++; if (rf_wbck_rdidx !== 5'd0) begin errors++; $display("FAIL reset_rdidx: got %0d want 0", rf_wbck_rdidx); end
    checks++; if (disp_alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", disp_alloc_ready); end
    checks++; if (disp_alloc_itag !== 2'd0) begin errors++; $display("FAIL reset_itag: got %0d want 0", disp_alloc_itag); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      disp_alloc_valid = 1'b1;
      disp_alloc_rdwen = 1'b1;
      disp_alloc_rdidx = idx_tab[i];
      disp_alloc_pc    = 32'h8000_0000 + 32'(4 * i);
      #1;
      checks++; if (disp_alloc_itag !== 2'(i)) begin errors++; $display("FAIL fill_itag%0d: got %0d want %0d", i, disp_alloc_itag, i); end
      checks++; if (disp_alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", i, disp_alloc_ready); end
      cyc();
    end
    disp_alloc_valid = 1'b0;
    #1;
    checks++; if (disp_alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", disp_alloc_ready); end
    checks++; if (oitf_empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", oitf_empty); end
  endtask

  task automatic test_full_wrap();
    disp_alloc_valid = 1'b1;
    disp_alloc_rdidx = 5'd9;
    disp_alloc_pc    = 32'h8000_0010;
    lsu_i_valid      = 1'b1;
    lsu_i_itag       = 2'd0;
    lsu_i_wdat       = 32'h1111_1111;
    #1;
    checks++; if (disp_alloc_ready !== 1'b0) begin errors++; $display("FAIL wrap_blocked: got %b want 0", disp_alloc_ready); end
    checks++; if (lsu_i_ready !== 1'b1) begin errors++; $display("FAIL wrap_lsu_ready: got %b want 1", lsu_i_ready); end
    cyc();
    lsu_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || rf_wbck_wdat !== 32'h1111_1111 || rf_wbck_rdidx !== 5'd3) begin
      errors++; $display("FAIL wrap_rf: got ena=%b %h x%0d want ena=1 11111111 x3", rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx);
    end
    checks++; if (disp_alloc_ready !== 1'b1 || disp_alloc_itag !== 2'd0) begin
      errors++; $display("FAIL wrap_accept: got ready=%b itag=%0d want ready=1 itag=0", disp_alloc_ready, disp_alloc_itag);
    end
    cyc();
    disp_alloc_valid = 1'b0;
    #1;
    checks++; if (disp_alloc_ready !== 1'b0) begin errors++; $display("FAIL wrap_refull: got %b want 0", disp_alloc_ready); end
  endtask

  task automatic test_tag_order();
    lsu_i_valid = 1'b1;
    lsu_i_itag  = 2'd2;
    lsu_i_wdat  = 32'hAAAA_AAAA;
    #1;
    checks++; if (lsu_i_ready !== 1'b0) begin errors++; $display("FAIL order_stall0: got %b want 0", lsu_i_ready); end
    cyc();
    #1;
    checks++; if (lsu_i_ready !== 1'b0) begin errors++; $display("FAIL order_stall1: got %b want 0", lsu_i_ready); end
    checks++; if (rf_wbck_ena !== 1'b0) begin errors++; $display("FAIL order_no_write: got %b want 0", rf_wbck_ena); end
    lsu_i_itag = 2'd1;
    lsu_i_wdat = 32'h6666_6666;
    #1;
    checks++; if (lsu_i_ready !== 1'b1) begin errors++; $display("FAIL order_head_ready: got %b want 1", lsu_i_ready); end
    cyc();
    lsu_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || rf_wbck_wdat !== 32'h6666_6666 || rf_wbck_rdidx !== 5'd6) begin
      errors++; $display("FAIL order_rf: got ena=%b %h x%0d want ena=1 66666666 x6", rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx);
    end
  endtask

  task automatic test_lsu_alu_priority();
    lsu_i_valid      = 1'b1;
    lsu_i_itag       = 2'd2;
    lsu_i_wdat       = 32'hDEAD_BEEF;
    alu_wbck_i_valid = 1'b1;
    alu_wbck_i_wdat  = 32'h1234_5678;
    alu_wbck_i_rdidx = 5'd10;
    #1;
    checks++; if (alu_wbck_i_ready !== 1'b0) begin errors++; $display("FAIL prio_alu_blocked: got %b want 0", alu_wbck_i_ready); end
    checks++; if (lsu_i_ready !== 1'b1) begin errors++; $display("FAIL prio_lsu_ready: got %b want 1", lsu_i_ready); end
    cyc();
    lsu_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || rf_wbck_wdat !== 32'hDEAD_BEEF || rf_wbck_rdidx !== 5'd5) begin
      errors++; $display("FAIL prio_lsu_rf: got ena=%b %h x%0d want ena=1 deadbeef x5", rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx);
    end
    checks++; if (alu_wbck_i_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready: got %b want 1", alu_wbck_i_ready); end
    cyc();
    alu_wbck_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || rf_wbck_wdat !== 32'h1234_5678 || rf_wbck_rdidx !== 5'd10) begin
      errors++; $display("FAIL prio_alu_rf: got ena=%b %h x%0d want ena=1 12345678 x10", rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx);
    end
    cyc();
    #1;
    checks++; if (rf_wbck_ena !== 1'b0) begin errors++; $display("FAIL idle_ena: got %b want 0", rf_wbck_ena); end
  endtask

  task automatic test_error();
    lsu_i_valid = 1'b1;
    lsu_i_itag  = 2'd3;
    lsu_i_wdat  = 32'h8888_8888;
    cyc();
    lsu_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || rf_wbck_wdat !== 32'h8888_8888 || rf_wbck_rdidx !== 5'd8) begin
      errors++; $display("FAIL err_pre_rf: got ena=%b %h x%0d want ena=1 88888888 x8", rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx);
    end
    lsu_i_valid        = 1'b1;
    lsu_i_itag         = 2'd0;
    lsu_i_wdat         = 32'hCAFE_F00D;
    lsu_i_err          = 1'b1;
    lsu_i_ld           = 1'b1;
    lsu_i_badaddr      = 32'h0000_BAD0;
    longp_excp_o_ready = 1'b0;
`ifdef E203_LONGP_EXCP_EN
    #1;
    checks++; if (lsu_i_ready !== 1'b0) begin errors++; $display("FAIL err_stall: got %b want 0", lsu_i_ready); end
    cyc();
    #1;
    checks++; if (rf_wbck_ena !== 1'b0) begin errors++; $display("FAIL err_stall_rf: got %b want 0", rf_wbck_ena); end
    longp_excp_o_ready = 1'b1;
    #1;
    checks++; if (lsu_i_ready !== 1'b1) begin errors++; $display("FAIL err_ready: got %b want 1", lsu_i_ready); end
    checks++; if (longp_excp_o_valid !== 1'b1 || longp_excp_o_pc !== 32'h8000_0010 || longp_excp_o_buserr !== 1'b1) begin
      errors++; $display("FAIL err_excp: got v=%b pc=%h buserr=%b want v=1 pc=80000010 buserr=1",
                         longp_excp_o_valid, longp_excp_o_pc, longp_excp_o_buserr);
    end
    checks++; if (longp_excp_o_badaddr !== 32'h0000_BAD0 || longp_excp_o_ld !== 1'b1 || longp_excp_o_st !== 1'b0) begin
      errors++; $display("FAIL err_payload: got badaddr=%h ld=%b st=%b want 0000bad0 1 0",
                         longp_excp_o_badaddr, longp_excp_o_ld, longp_excp_o_st);
    end
    cyc();
    lsu_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b0) begin errors++; $display("FAIL err_no_write: got %b want 0", rf_wbck_ena); end
`else
    #1;
    checks++; if (lsu_i_ready !== 1'b1) begin errors++; $display("FAIL noexcp_ready: got %b want 1", lsu_i_ready); end
    checks++; if (longp_excp_o_valid !== 1'b0 || longp_excp_o_pc !== 32'h0 || longp_excp_o_buserr !== 1'b0) begin
      errors++; $display("FAIL noexcp_tied: got v=%b pc=%h buserr=%b want all 0",
                         longp_excp_o_valid, longp_excp_o_pc, longp_excp_o_buserr);
    end
    cyc();
    lsu_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || rf_wbck_wdat !== 32'hCAFE_F00D || rf_wbck_rdidx !== 5'd9) begin
      errors++; $display("FAIL noexcp_rf: got ena=%b %h x%0d want ena=1 cafef00d x9", rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx);
    end
`endif
    checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL err_drained: got %b want 1", oitf_empty); end
    lsu_i_err          = 1'b0;
    lsu_i_ld           = 1'b0;
    longp_excp_o_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      disp_alloc_valid = 1'b1;
      disp_alloc_rdidx = 5'(20 + i);
      disp_alloc_pc    = 32'h9000_0000 + 32'(4 * i);
      if (i == 2) begin
        alu_wbck_i_valid = 1'b1;
        alu_wbck_i_wdat  = 32'h0000_0077;
        alu_wbck_i_rdidx = 5'd12;
      end
      #1;
      checks++; if (disp_alloc_itag !== 2'(i + 1)) begin errors++; $display("FAIL rst_alloc_itag%0d: got %0d want %0d", i, disp_alloc_itag, i + 1); end
      cyc();
    end
    disp_alloc_valid = 1'b0;
    alu_wbck_i_valid = 1'b0;
    #1;
    checks++; if (rf_wbck_ena !== 1'b1 || oitf_empty !== 1'b0) begin
      errors++; $display("FAIL rst_pre: got ena=%b empty=%b want ena=1 empty=0", rf_wbck_ena, oitf_empty);
    end
    rst = 1'b1;
    #1;
    checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", oitf_empty); end
    checks++; if (rf_wbck_ena !== 1'b0 || rf_wbck_wdat !== 32'h0) begin
      errors++; $display("FAIL rst_mid_rf: got ena=%b wdat=%h want 0 0", rf_wbck_ena, rf_wbck_wdat);
    end
    cyc();
    rst = 1'b0;
    disp_alloc_valid = 1'b1;
    #1;
    checks++; if (disp_alloc_itag !== 2'd0 || disp_alloc_ready !== 1'b1) begin
      errors++; $display("FAIL rst_next_itag: got itag=%0d ready=%b want 0 1", disp_alloc_itag, disp_alloc_ready);
    end
    cyc();
    disp_alloc_valid = 1'b0;
    #1;
    checks++; if (oitf_empty !== 1'b0) begin errors++; $display("FAIL rst_post_alloc: got %b want 0", oitf_empty); end
  endtask

  initial begin
    rst                = 1'b1;
    disp_alloc_valid   = 1'b0;
    disp_alloc_rdwen   = 1'b0;
    disp_alloc_rdidx   = '0;
    disp_alloc_pc      = '0;
    lsu_i_valid        = 1'b0;
    lsu_i_wdat         = '0;
    lsu_i_itag         = '0;
    lsu_i_err          = 1'b0;
    lsu_i_ld           = 1'b0;
    lsu_i_st           = 1'b0;
    lsu_i_badaddr      = '0;
    alu_wbck_i_valid   = 1'b0;
    alu_wbck_i_wdat    = '0;
    alu_wbck_i_rdidx   = '0;
    longp_excp_o_ready = 1'b0;
    cyc();
    cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_fill();
    test_full_wrap();
    test_tag_order();
    test_lsu_alu_priority();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_exu_longp_wbck.md
E203_EXU_LONGP_WBCK -- requirements
Module: e203_exu_longp_wbck

Interface
REQ-001 Parameter OITF_DEPTH, default 4: number of outstanding long-pipe entries; power of two, minimum 2.
REQ-002 Parameter ITAG_W, default 2: tag width; SHALL equal log2(OITF_DEPTH).
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-high, port rst.
REQ-004 clk  in  1  core clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 disp_alloc_valid  in  1  dispatch requests a long-pipe entry.
REQ-007 disp_alloc_ready  out  1  entry available.
REQ-008 disp_alloc_rdwen, disp_alloc_rdidx, disp_alloc_pc  in  1/5/32  destination write enable, register index and PC.
REQ-009 disp_alloc_itag  out  ITAG_W  tag assigned to this allocation.
REQ-010 oitf_empty  out  1  no outstanding entries.
REQ-011 lsu_i_valid, lsu_i_ready  in/out  1/1  LSU response handshake.
REQ-012 lsu_i_wdat, lsu_i_itag, lsu_i_err, lsu_i_ld, lsu_i_st, lsu_i_badaddr  in  32/ITAG_W/1/1/1/32  LSU response payload.
REQ-013 alu_wbck_i_valid, alu_wbck_i_ready  in/out  1/1  ALU writeback handshake.
REQ-014 alu_wbck_i_wdat, alu_wbck_i_rdidx  in  32/5  ALU writeback payload.
REQ-015 rf_wbck_ena, rf_wbck_wdat, rf_wbck_rdidx  out  1/32/5  registered register-file write port.
REQ-016 longp_excp_o_valid, longp_excp_o_ready  out/in  1/1  exception handshake to commit.
REQ-017 longp_excp_o_ld, longp_excp_o_st, longp_excp_o_buserr, longp_excp_o_badaddr, longp_excp_o_pc  out  1/1/1/32/32  exception payload.

Function
REQ-018 The OITF SHALL be a circular FIFO with wr_ptr and rd_ptr, each ITAG_W+1 bits; the extra MSB is the wrap bit.
REQ-019 Empty SHALL be wr_ptr==rd_ptr; full SHALL be equal low bits with differing MSBs.
REQ-020 disp_alloc_ready SHALL be !full; a full OITF SHALL block allocation even if a retire happens in the same cycle.
REQ-021 disp_alloc_itag SHALL be wr_ptr[ITAG_W-1:0].
REQ-022 On an allocation handshake the entry SHALL store rdwen, rdidx and pc, and wr_ptr SHALL increment, wrapping modulo 2*OITF_DEPTH.
REQ-023 lsu_i_ready SHALL be 1 only when the OITF is non-empty, lsu_i_itag==rd_ptr low bits, and (lsu_i_err==0 or longp_excp_o_ready==1).
REQ-024 A tag mismatch or an empty OITF SHALL stall the LSU response; it SHALL NOT be dropped.
REQ-025 Retire means an LSU handshake; on retire rd_ptr SHALL increment.
REQ-026 On a retire without error and with head rdwen==1, the next cycle SHALL present rf_wbck_ena=1 with lsu_i_wdat and the head rdidx (1-cycle latency).
REQ-027 On a retire with error, longp_excp_o_valid SHALL be asserted combinationally with the head pc, and the RF write SHALL be suppressed.
REQ-028 alu_wbck_i_ready SHALL be !(lsu_i_valid && lsu_i_ready): the long pipe has priority.
REQ-029 An accepted ALU writeback SHALL produce rf_wbck_ena=1 with the ALU data and index the next cycle.
REQ-030 rf_wbck_ena SHALL be 0 in any cycle that follows no accepted writeback.
REQ-031 Allocation and retire in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-032 oitf_empty SHALL be combinational from the pointers.

Reset
REQ-033 Reset SHALL clear both pointers to 0 and drive rf_wbck_ena=0, rf_wbck_wdat=0 and rf_wbck_rdidx=0.
REQ-034 Reset SHALL NOT clear OITF payload storage.
REQ-035 Reset asserted mid-operation SHALL discard all outstanding entries; oitf_empty SHALL be 1 from the cycle after reset.

Configuration
REQ-036 Macro E203_LONGP_EXCP_EN defined: error handling SHALL follow REQ-023 and REQ-027.
REQ-037 Macro E203_LONGP_EXCP_EN undefined: lsu_i_err SHALL be ignored, data SHALL be written as for a non-error retire, and all longp_excp_o_* outputs SHALL be tied to 0.

Structure
REQ-038 The shared package e203_exu_pkg SHALL hold the OITF entry struct (rdwen, rdidx, pc) and the default OITF_DEPTH and ITAG_W constants.
REQ-039 The pointer/full/empty logic SHALL be a sub-module, e203_exu_oitf_ptr.

Verification
REQ-040 Allocate 4 entries with no retire -> itags 0,1,2,3; disp_alloc_ready=0 after the 4th; oitf_empty=0.
REQ-041 Full OITF, then an allocation request together with a retire of itag 0 -> allocation blocked that cycle, accepted the next cycle with itag 0 (wrap).
REQ-042 Response itag 1 while the head is itag 0 -> lsu_i_ready=0 until itag 0 retires.
REQ-043 Retire with wdat=32'hDEADBEEF and rdidx=5 while an ALU writeback is valid -> RF write of DEADBEEF to x5 the next cycle; the ALU write is accepted one cycle later.
REQ-044 Error response with head pc=32'h80000010 and longp_excp_o_ready=0 -> stall; when ready rises, excp_pc=80000010, buserr=1, and no RF write.
REQ-045 Assert rst with 3 entries outstanding -> oitf_empty=1, rf_wbck_ena=0, next allocation receives itag 0.
